// File: rtl/watch_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : watch_mode_ctrl
//  Purpose  : Mode and display controller for the watch front panel.
//             Steps through NUM_MODES display sources with the mode button.
//             Runs a cursor-based edit FSM (set / next / up) that loads,
//             edits and commits a digit buffer for settable modes. Drives a
//             registered DIGITS-wide BCD/char bus to the decoder bank.
//  Ports    : clk_i, reset_i       - clock, synchronous active-high reset
//             *_btn_i              - level buttons, rising edge = one event
//             src_digits_i         - packed per-mode digit sources
//             src_is_char_i        - per-mode char-code flag
//             mode_o, editing_o    - current mode and edit status
//             disp_digits_o        - registered display bus
//             numorchar_o          - registered char flag of current mode
//             commit_o/_mode_o/_value_o - one-cycle commit of edited buffer
//  Revision : 1.0 - initial release
// ============================================================================
module watch_mode_ctrl #(
  parameter int              NUM_MODES  = 4,
  parameter int              DIGITS     = 7,
  parameter logic [3:0]      SETTABLE   = 4'b1101,
  parameter int              DIGIT_MAX  = 9,
  parameter int              BLINK_DIV  = 500,
  parameter logic [3:0]      BLANK_CODE = 4'hF,
  localparam int             MODE_W     = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        mode_btn_i,
  input  logic                        set_btn_i,
  input  logic                        next_btn_i,
  input  logic                        up_btn_i,
  input  logic [NUM_MODES*DIGITS*4-1:0] src_digits_i,
  input  logic [NUM_MODES-1:0]        src_is_char_i,
  output logic [MODE_W-1:0]           mode_o,
  output logic                        editing_o,
  output logic [DIGITS*4-1:0]         disp_digits_o,
  output logic                        numorchar_o,
  output logic                        commit_o,
  output logic [MODE_W-1:0]           commit_mode_o,
  output logic [DIGITS*4-1:0]         commit_value_o
);

  localparam int CUR_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EDIT = 1'b1;

  // Button sync/edge registers; bit 0 mode, 1 set, 2 next, 3 up
  logic [3:0]              btn_q, btn_q2;
  logic [3:0]              w_evt;
  logic                    w_ev_mode, w_ev_set, w_ev_next, w_ev_up;

  logic [0:0]              state_q, state_d;
  logic [MODE_W-1:0]       mode_q, mode_d;
  logic [CUR_W-1:0]        cursor_q, cursor_d;
  logic [DIGITS*4-1:0]     buf_q, buf_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    blink_off_q, blink_off_d;
  logic [DIGITS*4-1:0]     disp_q, disp_d;
  logic                    numorchar_q, numorchar_d;
  logic                    commit_q, commit_d;
  logic [MODE_W-1:0]       commit_mode_q, commit_mode_d;
  logic [DIGITS*4-1:0]     commit_value_q, commit_value_d;

  logic                    w_editing;
  logic                    w_load;
  logic                    w_commit;
  logic [DIGITS*4-1:0]     w_src [NUM_MODES];

  // Unpack the per-mode source slices
  for (genvar m = 0; m < NUM_MODES; m++) begin : g_src
    assign w_src[m] = src_digits_i[m*DIGITS*4 +: DIGITS*4];
  end

  // Only the highest-priority event acts: mode > set > next > up
  assign w_evt     = btn_q & ~btn_q2;
  assign w_ev_mode = w_evt[0];
  assign w_ev_set  = w_evt[1] & ~w_evt[0];
  assign w_ev_next = w_evt[2] & ~|w_evt[1:0];
  assign w_ev_up   = w_evt[3] & ~|w_evt[2:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_ev_set && SETTABLE[mode_q]) state_d = S_EDIT;
      S_EDIT:  if (w_ev_mode || w_ev_set)         state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_editing = (state_q == S_EDIT);
    w_load    = (state_q == S_IDLE) && w_ev_set && SETTABLE[mode_q];
    w_commit  = (state_q == S_EDIT) && w_ev_set;
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    mode_d         = mode_q;
    cursor_d       = cursor_q;
    buf_d          = buf_q;
    blink_cnt_d    = '0;
    blink_off_d    = 1'b0;
    commit_d       = w_commit;
    commit_mode_d  = commit_mode_q;
    commit_value_d = commit_value_q;

    if (!w_editing && w_ev_mode) begin
      mode_d = (mode_q == MODE_W'(NUM_MODES-1)) ? '0 : mode_q + 1'b1;
    end

    if (w_load) begin
      buf_d    = w_src[mode_q];
      cursor_d = CUR_W'(DIGITS-1);
    end else if (w_editing && w_ev_next) begin
      cursor_d = (cursor_q == '0) ? CUR_W'(DIGITS-1) : cursor_q - 1'b1;
    end else if (w_editing && w_ev_up) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (cursor_q == CUR_W'(d)) begin
          // ">=" also folds out-of-range loaded codes back to 0
          buf_d[4*d +: 4] = (buf_q[4*d +: 4] >= 4'(DIGIT_MAX)) ? 4'h0
                                                             : buf_q[4*d +: 4] + 4'h1;
        end
      end
    end

    // Blink runs only while staying in EDIT with no cursor/digit activity;
    // everything else (idle, entry, next/up, exit) restarts it visible.
    if (w_editing && (state_d == S_EDIT) && !w_ev_next && !w_ev_up) begin
      if (blink_cnt_q == BLINK_W'(BLINK_DIV-1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_off_d = blink_off_q;
      end
    end

    if (w_commit) begin
      commit_mode_d  = mode_q;
      commit_value_d = buf_q;
    end
  end

  // Display is built from the registered state, hence one extra cycle
  always_comb begin
    disp_d      = w_src[mode_q];
    numorchar_d = src_is_char_i[mode_q];
    if (w_editing) begin
      disp_d = buf_q;
      if (blink_off_q) begin
        for (int d = 0; d < DIGITS; d++) begin
          if (cursor_q == CUR_W'(d)) disp_d[4*d +: 4] = BLANK_CODE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      btn_q          <= '0;
      btn_q2         <= '0;
      mode_q         <= '0;
      cursor_q       <= CUR_W'(DIGITS-1);
      buf_q          <= '0;
      blink_cnt_q    <= '0;
      blink_off_q    <= 1'b0;
      disp_q         <= '0;
      numorchar_q    <= 1'b0;
      commit_q       <= 1'b0;
      commit_mode_q  <= '0;
      commit_value_q <= '0;
    end else begin
      btn_q          <= {up_btn_i, next_btn_i, set_btn_i, mode_btn_i};
      btn_q2         <= btn_q;
      mode_q         <= mode_d;
      cursor_q       <= cursor_d;
      buf_q          <= buf_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_off_q    <= blink_off_d;
      disp_q         <= disp_d;
      numorchar_q    <= numorchar_d;
      commit_q       <= commit_d;
      commit_mode_q  <= commit_mode_d;
      commit_value_q <= commit_value_d;
    end
  end

  assign mode_o         = mode_q;
  assign editing_o      = w_editing;
  assign disp_digits_o  = disp_q;
  assign numorchar_o    = numorchar_q;
  assign commit_o       = commit_q;
  assign commit_mode_o  = commit_mode_q;
  assign commit_value_o = commit_value_q;

endmodule
`default_nettype wire

// File: doc/watch_mode_ctrl.md
# watch_mode_ctrl

Parametrised mode and display controller for the watch front panel. It sequences through `NUM_MODES` display sources with a mode button. It runs a cursor-based edit FSM (set / next / up) that loads, edits and commits a digit buffer for settable modes. It drives a registered `DIGITS`-wide BCD/char bus into the seven-segment decoders. It sits between the time-keeping modules (watch, stopwatch, alarm, day) and the decoder bank, and replaces the fixed four-mode display mux.

## Interface
Parameters:
- `NUM_MODES`, 4: number of display sources; mode index wraps at NUM_MODES-1.
- `DIGITS`, 7: number of 4-bit display digits.
- `SETTABLE`, 4'b1101: bit m=1 means mode m accepts edit (default: watch, alarm, day).
- `DIGIT_MAX`, 9: `up` increments a digit 0..DIGIT_MAX and then wraps to 0.
- `BLINK_DIV`, 500: clk cycles per blink half-period.
- `BLANK_CODE`, 4'hF: digit code the decoder renders as blank.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `mode_btn` in 1: level; a rising edge advances the mode or aborts an edit.
- `set_btn` in 1: level; a rising edge enters edit or commits it.
- `next_btn` in 1: level; a rising edge moves the cursor one digit right.
- `up_btn` in 1: level; a rising edge increments the digit under the cursor.
- `src_digits` in NUM_MODES*DIGITS*4: packed sources; mode m occupies bits [(m+1)*DIGITS*4-1 : m*DIGITS*4], and digit d within it occupies [4d+3:4d].
- `src_is_char` in NUM_MODES: bit m=1 means mode m carries char codes, not numbers.
- `mode` out clog2(NUM_MODES): current mode.
- `editing` out 1: high while in EDIT.
- `disp_digits` out DIGITS*4: registered display bus.
- `numorchar` out 1: registered; equals src_is_char[mode].
- `commit` out 1: one-cycle pulse when an edit is accepted.
- `commit_mode` out clog2(NUM_MODES): mode being committed; valid with `commit`.
- `commit_value` out DIGITS*4: edited buffer; valid with `commit`.

## Operation
- Buttons:
  - Each button is registered once (`b_q`, `b_q2`); event = `b_q & ~b_q2`.
  - Holding a button produces exactly one event.
- Event priority in one cycle: mode > set > next > up. Only the highest-priority event acts; the others are discarded.
- FSM states: IDLE, EDIT.
- IDLE:
  - Mode event: `mode <= (mode==NUM_MODES-1) ? 0 : mode+1`.
  - Set event with SETTABLE[mode]=1: load `buf` from the source slice of the current mode, set `cursor <= DIGITS-1` (leftmost), go to EDIT.
  - Set event with SETTABLE[mode]=0: ignored.
  - Next and up events: ignored.
- EDIT:
  - Next event: `cursor <= (cursor==0) ? DIGITS-1 : cursor-1`.
  - Up event: `buf[cursor] <= (buf[cursor]>=DIGIT_MAX) ? 0 : buf[cursor]+1`. Out-of-range loaded values (for example 4'hC) also go to 0.
  - Set event: pulse `commit` with `commit_mode=mode` and `commit_value=buf`, then go to IDLE.
  - Mode event: abort. Go to IDLE with no commit; `mode` is unchanged.
  - The source slice is not tracked while editing; `buf` is frozen except through the edit events above.
- Display:
  - IDLE: `disp_digits <= src slice[mode]`.
  - EDIT: `disp_digits <= buf`, with the cursor digit replaced by BLANK_CODE while `blink_off`=1.
- Blink:
  - A counter runs 0..BLINK_DIV-1 only in EDIT; `blink_off` toggles on each wrap.
  - The counter clears to 0 and `blink_off` clears to 0 on entering EDIT and on every next or up event.
- `commit_value` and `commit_mode` hold their last value between pulses.

## Timing
- Reset values:
  - `mode`=0, state IDLE, `editing`=0, `cursor`=DIGITS-1, `buf`=0.
  - `disp_digits`=0, `numorchar`=0.
  - `commit`=0, `commit_mode`=0, `commit_value`=0.
  - Blink counter=0, `blink_off`=0, button registers=0.
- Latency, with a button first sampled high at edge k:
  - The event is valid during cycle k→k+1.
  - `mode`, `editing`, `cursor`, `buf` and `commit` update at edge k+1.
  - `disp_digits` and `numorchar` reflect the change at edge k+2.
- `src_digits` change → `disp_digits` change after 1 clk (registered pass-through).
- `commit` is high for exactly one cycle (edge k+1 to k+2).
- Reset mid-edit: `buf` is discarded, no `commit` is issued, and all outputs return to their reset values on the same edge.
- Reset takes priority over every event in the same cycle.

## Test plan
- Mode wrap: after reset, 4 `mode_btn` presses → `mode` reads 1,2,3,0. Holding the button 20 cycles gives one step only. With `src_is_char`=4'b1000, `numorchar`=1 only while mode=3.
- Non-settable: mode=1, set press → `editing` stays 0 and `commit` never pulses.
- Edit/commit:
  - Setup: mode=0, src slice = 0x1234000, set press → `editing`=1, cursor=6.
  - Stimulus: up ×3, next, up ×9.
  - Then a set press → one-cycle `commit` with `commit_value`=0x4134000 and `commit_mode`=0.
- Wrap rules: a digit at 9 plus up → 0. Cursor at 0 plus next → 6. Out-of-range digit 0xC plus up → 0.
- Priority and abort:
  - `mode_btn` and `up_btn` rising in the same cycle during EDIT → abort, `buf` untouched, no `commit`, `mode` unchanged.
  - `reset` asserted during EDIT → all outputs return to their reset values the next edge.
- Blink with BLINK_DIV=4 in EDIT:
  - The cursor digit shows BLANK_CODE for 4 cycles, then its value for 4 cycles, repeating.
  - An up press restarts the cycle with the value visible.
